// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared state encoding, card point value and rule thresholds
package baccarat_pkg;
  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL,
    DEAL_P3, SETTLE, BANKER, DEAL_D3, RESULT, DONE
  } state_t;
  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] STAND_MIN = 4'd6;
  function automatic logic [3:0] point_value(input logic [3:0] code);
    return (code <= 4'd9) ? code : 4'd0;
  endfunction
endpackage

// File: rtl/deal_sequencer_if.sv
// deal_sequencer_if: step/score inputs and strobe/light outputs of the sequencer
interface deal_sequencer_if;
  logic step;
  logic [3:0] pscore, dscore, pcard3;
  logic load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light, done;
  modport master (
    output step, pscore, dscore, pcard3,
    input load_pcard1, load_pcard2, load_pcard3,
    input load_dcard1, load_dcard2, load_dcard3,
    input player_win_light, dealer_win_light, done
  );
  modport slave (
    input step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );
endinterface

// File: rtl/banker_draw_rule.sv
// banker_draw_rule: banker third-card decision from its score and the player's third card value
module banker_draw_rule (
  input  logic [3:0] dscore_i,
  input  logic [3:0] pval_i,
  output logic       draw_o
);
  always_comb
    draw_o = (dscore_i <= 4'd2) ? 1'b1 :
             (dscore_i == 4'd3) ? (pval_i != 4'd8) :
             (dscore_i == 4'd4) ? (pval_i >= 4'd2 && pval_i <= 4'd7) :
             (dscore_i == 4'd5) ? (pval_i >= 4'd4 && pval_i <= 4'd7) :
             (dscore_i == 4'd6) ? (pval_i >= 4'd6 && pval_i <= 4'd7) : 1'b0;
endmodule

// File: rtl/deal_sequencer.sv
// deal_sequencer: step-driven baccarat round controller with registered load strobes and result lights
module deal_sequencer
  import baccarat_pkg::*;
(
  input logic slow_clock,
  input logic reset,
  deal_sequencer_if.slave bus
);
  state_t state_q;
  logic [3:0] dsc_q;
  logic ld_p1_q, ld_p2_q, ld_p3_q, ld_d1_q, ld_d2_q, ld_d3_q;
  logic pwin_q, dwin_q, done_q;
  logic draw;
  banker_draw_rule u_rule (
    .dscore_i(dsc_q),
    .pval_i(point_value(bus.pcard3)),
    .draw_o(draw)
  );
  // Round FSM: strobes default low and pulse for one cycle after an accepted step
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= DEAL_P1;
      dsc_q <= '0;
      {ld_p1_q, ld_p2_q, ld_p3_q, ld_d1_q, ld_d2_q, ld_d3_q} <= '0;
      {pwin_q, dwin_q, done_q} <= '0;
    end else begin
      {ld_p1_q, ld_p2_q, ld_p3_q, ld_d1_q, ld_d2_q, ld_d3_q} <= '0;
      case (state_q)
        DEAL_P1: if (bus.step) begin ld_p1_q <= 1'b1; state_q <= DEAL_D1; end
        DEAL_D1: if (bus.step) begin ld_d1_q <= 1'b1; state_q <= DEAL_P2; end
        DEAL_P2: if (bus.step) begin ld_p2_q <= 1'b1; state_q <= DEAL_D2; end
        DEAL_D2: if (bus.step) begin ld_d2_q <= 1'b1; state_q <= EVAL; end
        EVAL: if (bus.step) begin
          dsc_q <= bus.dscore;
          state_q <= (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN) ? RESULT :
                     (bus.pscore < STAND_MIN) ? DEAL_P3 :
                     (bus.dscore < STAND_MIN) ? DEAL_D3 : RESULT;
        end
        DEAL_P3: if (bus.step) begin ld_p3_q <= 1'b1; state_q <= SETTLE; end
        SETTLE: state_q <= BANKER;
        BANKER: state_q <= draw ? DEAL_D3 : RESULT;
        DEAL_D3: if (bus.step) begin ld_d3_q <= 1'b1; state_q <= RESULT; end
        RESULT: if (bus.step) begin
          pwin_q <= bus.pscore >= bus.dscore;
          dwin_q <= bus.dscore >= bus.pscore;
          done_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= DONE;
        default: state_q <= DEAL_P1;
      endcase
    end
  end
  assign bus.load_pcard1 = ld_p1_q;
  assign bus.load_pcard2 = ld_p2_q;
  assign bus.load_pcard3 = ld_p3_q;
  assign bus.load_dcard1 = ld_d1_q;
  assign bus.load_dcard2 = ld_d2_q;
  assign bus.load_dcard3 = ld_d3_q;
  assign bus.player_win_light = pwin_q;
  assign bus.dealer_win_light = dwin_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_deal_sequencer.sv
// tb_deal_sequencer: directed rounds with a queue scoreboard checked by an output monitor
module tb_deal_sequencer;
  import baccarat_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  deal_sequencer_if bus();
  deal_sequencer dut (.slow_clock(clk), .reset(rst), .bus(bus));
  localparam logic [8:0] P1 = 9'h001, P2 = 9'h002, P3 = 9'h004;
  localparam logic [8:0] D1 = 9'h008, D2 = 9'h010, D3 = 9'h020;
  logic [8:0] exp_q[$];
  logic [8:0] obs, exp_v;
  logic [2:0] prev_st;
  int checks = 0, errors = 0;
  assign obs = {bus.player_win_light, bus.dealer_win_light, bus.done,
                bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
  function automatic logic [8:0] fin(input logic pw, input logic dw);
    return {pw, dw, 1'b1, 6'b0};
  endfunction
  always @(posedge clk) begin
    #1;
    if (rst) prev_st = obs[8:6];
    else if (|obs[5:0] || obs[8:6] != prev_st) begin
      prev_st = obs[8:6];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h required none", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (exp_v !== obs) begin
          errors++;
          $display("FAIL output got %h required %h", obs, exp_v);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", n, got, want);
    end
  endtask
  task automatic pulse(input logic [8:0] e);
    if (e != 9'h0) exp_q.push_back(e);
    @(negedge clk) bus.step = 1'b1;
    @(negedge clk) bus.step = 1'b0;
    tick(3);
  endtask
  task automatic do_reset();
    @(negedge clk) begin rst = 1'b1; bus.step = 1'b0; end
    tick(2);
    rst = 1'b0;
  endtask
  task automatic deal4();
    pulse(P1); pulse(D1); pulse(P2); pulse(D2);
  endtask
  task automatic drained(input string n);
    chk(n, exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    bus.step = 1'b0; bus.pscore = 4'd0; bus.dscore = 4'd0; bus.pcard3 = 4'd1;
    tick(3);
    chk("reset_outputs", obs, 0);
    chk("reset_state", dut.state_q, DEAL_P1);
    rst = 1'b0;
    deal4();
    chk("after_deal4_state", dut.state_q, EVAL);
    bus.pscore = 4'd8; bus.dscore = 4'd3;
    pulse(0);
    chk("natural_to_result", dut.state_q, RESULT);
    pulse(fin(1, 0));
    chk("done_high", bus.done, 1);
    pulse(0); pulse(0); pulse(0);
    tick(100);
    chk("done_holds", obs, fin(1, 0));
    chk("done_state", dut.state_q, DONE);
    drained("round_natural");
    do_reset();
    chk("reset_clears_lights", obs, 0);
    deal4();
    tick(100);
    chk("idle_hold_eval", dut.state_q, EVAL);
    bus.pscore = 4'd4; bus.dscore = 4'd3; bus.pcard3 = 4'd8;
    pulse(0);
    chk("player_draws", dut.state_q, DEAL_P3);
    pulse(P3);
    chk("banker3_stands_on_8", dut.state_q, RESULT);
    pulse(fin(1, 0));
    drained("round_p3_stand");
    do_reset();
    deal4();
    bus.pscore = 4'd2; bus.dscore = 4'd4; bus.pcard3 = 4'd12;
    pulse(0);
    pulse(P3);
    chk("banker4_stands_on_face", dut.state_q, RESULT);
    pulse(fin(0, 1));
    drained("round_face");
    do_reset();
    deal4();
    bus.pscore = 4'd2; bus.dscore = 4'd4; bus.pcard3 = 4'd5;
    pulse(0);
    pulse(P3);
    chk("banker4_draws_on_5", dut.state_q, DEAL_D3);
    pulse(D3);
    chk("after_d3_state", dut.state_q, RESULT);
    pulse(fin(0, 1));
    drained("round_p3_d3");
    do_reset();
    deal4();
    bus.pscore = 4'd7; bus.dscore = 4'd5;
    pulse(0);
    chk("player_stands_dealer_draws", dut.state_q, DEAL_D3);
    pulse(D3);
    bus.pscore = 4'd6; bus.dscore = 4'd6;
    pulse(fin(1, 1));
    drained("round_tie");
    do_reset();
    deal4();
    bus.pscore = 4'd3; bus.dscore = 4'd9;
    pulse(0);
    chk("dealer_natural", dut.state_q, RESULT);
    pulse(fin(0, 1));
    drained("round_dealer_natural");
    do_reset();
    pulse(P1);
    exp_q.push_back(D1);
    @(negedge clk) bus.step = 1'b1;
    @(negedge clk) begin bus.step = 1'b0; rst = 1'b1; end
    chk("dcard1_high_at_reset", bus.load_dcard1, 1);
    @(negedge clk);
    chk("reset_drops_strobe", obs, 0);
    chk("reset_mid_state", dut.state_q, DEAL_P1);
    rst = 1'b0;
    tick(10);
    pulse(P1);
    chk("restart_state", dut.state_q, DEAL_D1);
    @(negedge clk) begin rst = 1'b1; bus.step = 1'b1; end
    @(negedge clk) bus.step = 1'b0;
    chk("reset_priority_state", dut.state_q, DEAL_P1);
    chk("reset_priority_outputs", obs, 0);
    rst = 1'b0;
    tick(5);
    drained("round_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
